// File: rtl/keynsham_bus_decoder.sv
// keynsham_bus_decoder: single-master, N-slave data-bus decoder with default-slave error.
// Optional WAIT timeout when KEYNSHAM_BUS_TIMEOUT_EN is defined.
module keynsham_bus_decoder #(
  parameter int NUM_SLAVES = 4,
  parameter int ADDR_W = 30,
  parameter int DATA_W = 32,
  parameter logic [NUM_SLAVES*ADDR_W-1:0] SLV_BASE =
    {30'h0C000000, 30'h08000000, 30'h04000000, 30'h00000000},
  parameter logic [NUM_SLAVES*ADDR_W-1:0] SLV_MASK =
    {4{30'h3FFFFC00}},
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         m_access,
  input  logic [ADDR_W-1:0]            m_addr,
  output logic [DATA_W-1:0]            m_data,
  output logic                         m_ack,
  output logic                         m_error,
  output logic                         busy,
  output logic [NUM_SLAVES-1:0]        s_cs,
  output logic [NUM_SLAVES-1:0]        s_access,
  input  logic [NUM_SLAVES*DATA_W-1:0] s_data,
  input  logic [NUM_SLAVES-1:0]        s_ack,
  input  logic [NUM_SLAVES-1:0]        s_error
);

  localparam int SEL_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_DFLT = 2'd2;

  logic [1:0]            r_state;
  logic [1:0]            w_state_nxt;
  logic [SEL_W-1:0]      r_sel;
  logic [SEL_W-1:0]      w_hit_idx;
  logic                  w_any_hit;
  logic [NUM_SLAVES-1:0] w_cs;
  logic                  w_start;
  logic [DATA_W-1:0]     w_sdata;
  logic                  w_sack;
  logic                  w_serr;
  logic                  w_in_wait;
  logic                  w_in_dflt;
  logic                  w_ack;
  logic                  w_timeout;

  // Scan high-to-low so the lowest matching index is the one kept.
  always_comb begin
    w_hit_idx = '0;
    w_any_hit = 1'b0;
    w_cs      = '0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if (((m_addr ^ SLV_BASE[i*ADDR_W +: ADDR_W]) &
           SLV_MASK[i*ADDR_W +: ADDR_W]) == '0) begin
        w_hit_idx = SEL_W'(i);
        w_any_hit = 1'b1;
        w_cs      = '0;
        w_cs[i]   = 1'b1;
      end
    end
  end

  assign s_cs     = w_cs;
  assign w_start  = m_access && (r_state == S_IDLE);
  assign s_access = w_start ? w_cs : '0;

  always_comb begin
    w_sdata = '0;
    w_sack  = 1'b0;
    w_serr  = 1'b0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (r_sel == SEL_W'(i)) begin
        w_sdata = s_data[i*DATA_W +: DATA_W];
        w_sack  = s_ack[i];
        w_serr  = s_error[i];
      end
    end
  end

  assign w_in_wait = (r_state == S_WAIT);
  assign w_in_dflt = (r_state == S_DFLT);
  assign w_ack     = w_in_wait & w_sack;
  assign m_ack     = w_ack | w_in_dflt;
  assign m_error   = (w_ack & w_serr) | w_in_dflt;
  assign m_data    = w_ack ? w_sdata : '0;
  assign busy      = (r_state != S_IDLE);

`ifdef KEYNSHAM_BUS_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_inc;

  assign w_cnt_inc = (r_cnt == TO_VAL) ? r_cnt : r_cnt + 1'b1;
  // A slave ack in the final cycle takes priority over the timeout.
  assign w_timeout = w_in_wait & ~w_sack & (w_cnt_inc == TO_VAL);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (w_start && w_any_hit) begin
      r_cnt <= '0;
    end else if (w_in_wait && !w_sack) begin
      r_cnt <= w_cnt_inc;
    end
  end
`else
  logic w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT_CYCLES != 0);
  assign w_timeout = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (m_access) begin
          w_state_nxt = w_any_hit ? S_WAIT : S_DFLT;
        end
      end
      S_WAIT: begin
        if (w_sack) begin
          w_state_nxt = S_IDLE;
        end else if (w_timeout) begin
          w_state_nxt = S_DFLT;
        end
      end
      S_DFLT:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_sel   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_start && w_any_hit) begin
        r_sel <= w_hit_idx;
      end
    end
  end

endmodule
